// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester: FSM states, address decode
// bit positions and default widths.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RDATA
  } state_e;

  localparam int SLV_SEL_BIT = 7;
  localparam int DEC_ERR_BIT = 6;

  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Request/response handshake plus the two-slave APB bus.
// The master modport is the requester's view, the slave modport is the opposite side.
interface apb_master_ctrl_if #(
  parameter int ADDR_WIDTH = apb_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = apb_pkg::DEF_DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  PSEL1;
  logic                  PSEL2;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA1;
  logic [DATA_WIDTH-1:0] PRDATA2;
  logic                  PREADY1;
  logic                  PREADY2;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  PRDATA1, PRDATA2, PREADY1, PREADY2,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output PRDATA1, PRDATA2, PREADY1, PREADY2,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles spent waiting for PREADY; expired is high once the
// count reaches TIMEOUT_CYCLES-1, and the count saturates there.
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB requester for two slaves: decodes a single request, runs SETUP/ACCESS,
// and returns a one-cycle response pulse with read data or an error.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic               PCLK,
  input logic               PRESETn,
  apb_master_ctrl_if.master bus
);

  state_e                state_q, state_d;
  logic                  psel1_q, psel1_d;
  logic                  psel2_q, psel2_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expired;
  logic sel_slave2;
  logic sel_ready;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(cnt_expired)
  );

  // The registered address remembers which slave owns the transfer, through RDATA.
  assign sel_slave2 = paddr_q[SLV_SEL_BIT];
  assign sel_ready  = sel_slave2 ? bus.PREADY2 : bus.PREADY1;

  always_comb begin
    state_d     = state_q;
    psel1_d     = psel1_q;
    psel2_d     = psel2_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    cnt_clear   = 1'b0;
    cnt_enable  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_addr[DEC_ERR_BIT]) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            paddr_d   = bus.req_addr;
            pwdata_d  = bus.req_wdata;
            pwrite_d  = bus.req_write;
            psel1_d   = !bus.req_addr[SLV_SEL_BIT];
            psel2_d   = bus.req_addr[SLV_SEL_BIT];
            cnt_clear = 1'b1;
            state_d   = SETUP;
          end
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (sel_ready) begin
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
          if (pwrite_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            state_d     = IDLE;
          end else begin
            state_d = RDATA;
          end
        end else if (cnt_expired) begin
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end else begin
          cnt_enable = 1'b1;
        end
      end

      RDATA: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = sel_slave2 ? bus.PRDATA2 : bus.PRDATA1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel1_q     <= psel1_d;
      psel2_q     <= psel2_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.PSEL1     = psel1_q;
  assign bus.PSEL2     = psel2_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: two behavioural 64-entry APB slaves,
// directed scenarios, then randomized traffic checked against a memory model.
module tb_apb_master_ctrl;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b1;

  always #5 PCLK = ~PCLK;

  apb_master_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master_ctrl #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // 0: slaves always ready, 1: random PREADY, 2: slave1 stuck not-ready
  int wait_mode = 0;

  logic [7:0] slv1_mem [64] = '{default: 8'h00};
  logic [7:0] slv2_mem [64] = '{default: 8'h00};
  logic [7:0] prdata1_r = 8'h00;
  logic [7:0] prdata2_r = 8'h00;
  logic       pready1_r = 1'b1;
  logic       pready2_r = 1'b1;

  logic [7:0] ref1 [64];
  logic [7:0] ref2 [64];

  assign bus.PRDATA1 = prdata1_r;
  assign bus.PRDATA2 = prdata2_r;
  assign bus.PREADY1 = pready1_r;
  assign bus.PREADY2 = pready2_r;

  // Slaves latch the read address at access completion, so PRDATA lags by a cycle.
  always @(posedge PCLK) begin
    if (bus.PSEL1 && bus.PENABLE && pready1_r) begin
      if (bus.PWRITE) slv1_mem[bus.PADDR[5:0]] <= bus.PWDATA;
      else            prdata1_r <= slv1_mem[bus.PADDR[5:0]];
    end
    if (bus.PSEL2 && bus.PENABLE && pready2_r) begin
      if (bus.PWRITE) slv2_mem[bus.PADDR[5:0]] <= bus.PWDATA;
      else            prdata2_r <= slv2_mem[bus.PADDR[5:0]];
    end
    case (wait_mode)
      0: begin
        pready1_r <= 1'b1;
        pready2_r <= 1'b1;
      end
      1: begin
        pready1_r <= ($urandom_range(0, 2) != 0);
        pready2_r <= ($urandom_range(0, 2) != 0);
      end
      default: begin
        pready1_r <= 1'b0;
        pready2_r <= 1'b1;
      end
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request, then follows it cycle by cycle until the response pulse.
  // exp_lat > 0 demands an exact latency; otherwise only the minimum is enforced.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                               input int exp_lat, input logic exp_timeout, input string tag);
    logic       exp_err;
    logic [7:0] exp_rdata;
    logic       sel2;
    logic       sel_psel;
    logic       got;
    int         n;
    int         en_cycles;
    int         min_lat;

    sel2      = addr[7];
    exp_err   = addr[6] | exp_timeout;
    exp_rdata = 8'h00;
    if (!exp_err && !wr) exp_rdata = sel2 ? ref2[addr[5:0]] : ref1[addr[5:0]];
    if (!exp_err && wr) begin
      if (sel2) ref2[addr[5:0]] = wdata;
      else      ref1[addr[5:0]] = wdata;
    end
    min_lat = addr[6] ? 1 : (wr ? 3 : 4);

    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge PCLK);
    checkOutput({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge PCLK);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom_range(0, 1));
    bus.req_addr  = 8'($urandom);
    bus.req_wdata = 8'($urandom);

    got       = 1'b0;
    n         = 0;
    en_cycles = 0;
    while (!got && n < 40) begin
      @(negedge PCLK);
      n++;
      sel_psel = sel2 ? bus.PSEL2 : bus.PSEL1;
      checkOutput({tag, " psel_excl"}, 32'(bus.PSEL1 & bus.PSEL2), 32'd0);
      checkOutput({tag, " other_psel"},
                  32'(addr[6] ? (bus.PSEL1 | bus.PSEL2) : (sel2 ? bus.PSEL1 : bus.PSEL2)), 32'd0);
      if (bus.PSEL1 | bus.PSEL2) begin
        checkOutput({tag, " paddr"}, 32'(bus.PADDR), 32'(addr));
        checkOutput({tag, " pwrite"}, 32'(bus.PWRITE), 32'(wr));
        if (wr) checkOutput({tag, " pwdata"}, 32'(bus.PWDATA), 32'(wdata));
      end
      if (bus.PENABLE) en_cycles++;
      if (wait_mode == 0 && !exp_err) begin
        if (n == 1) begin
          checkOutput({tag, " setup_psel"}, 32'(sel_psel), 32'd1);
          checkOutput({tag, " setup_penable"}, 32'(bus.PENABLE), 32'd0);
        end
        if (n == 2) begin
          checkOutput({tag, " access_psel"}, 32'(sel_psel), 32'd1);
          checkOutput({tag, " access_penable"}, 32'(bus.PENABLE), 32'd1);
        end
        if (n == 3 && !wr) begin
          checkOutput({tag, " rdata_psel"}, 32'(sel_psel), 32'd0);
          checkOutput({tag, " rdata_penable"}, 32'(bus.PENABLE), 32'd0);
        end
      end
      if (bus.rsp_valid) got = 1'b1;
    end

    checkOutput({tag, " rsp_seen"}, 32'(got), 32'd1);
    if (exp_lat > 0) checkOutput({tag, " latency"}, 32'(n), 32'(exp_lat));
    else             checkOutput({tag, " latency_min"}, 32'(n >= min_lat), 32'd1);
    checkOutput({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
    checkOutput({tag, " rsp_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
    checkOutput({tag, " rsp_req_ready"}, 32'(bus.req_ready), 32'd1);
    checkOutput({tag, " rsp_psel_low"}, 32'(bus.PSEL1 | bus.PSEL2 | bus.PENABLE), 32'd0);
    if (exp_timeout) checkOutput({tag, " penable_cycles"}, 32'(en_cycles), 32'(TO));

    @(negedge PCLK);
    checkOutput({tag, " rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ref1[i] = 8'h00;
      ref2[i] = 8'h00;
    end
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;

    #1 PRESETn = 1'b0;
    #2;
    checkOutput("reset req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset PSEL1", 32'(bus.PSEL1), 32'd0);
    checkOutput("reset PSEL2", 32'(bus.PSEL2), 32'd0);
    checkOutput("reset PENABLE", 32'(bus.PENABLE), 32'd0);
    checkOutput("reset PWRITE", 32'(bus.PWRITE), 32'd0);
    checkOutput("reset PADDR", 32'(bus.PADDR), 32'd0);
    checkOutput("reset PWDATA", 32'(bus.PWDATA), 32'd0);
    checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("reset rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;

    $display("[TB] directed transfers");
    applyStimulus(1'b1, 8'h05, 8'hA5, 3, 1'b0, "wr05");
    applyStimulus(1'b0, 8'h05, 8'h00, 4, 1'b0, "rd05");
    applyStimulus(1'b1, 8'h85, 8'h3C, 3, 1'b0, "wr85");
    applyStimulus(1'b0, 8'h85, 8'h00, 4, 1'b0, "rd85");
    applyStimulus(1'b0, 8'h05, 8'h00, 4, 1'b0, "rd05_again");
    applyStimulus(1'b1, 8'h45, 8'h77, 1, 1'b0, "dec45");
    applyStimulus(1'b0, 8'hC0, 8'h00, 1, 1'b0, "decC0");
    applyStimulus(1'b1, 8'h3F, 8'h5E, 3, 1'b0, "wr3F");
    applyStimulus(1'b1, 8'hBF, 8'hE1, 3, 1'b0, "wrBF");
    applyStimulus(1'b0, 8'h3F, 8'h00, 4, 1'b0, "rd3F");
    applyStimulus(1'b0, 8'hBF, 8'h00, 4, 1'b0, "rdBF");

    $display("[TB] PREADY timeout");
    wait_mode = 2;
    applyStimulus(1'b0, 8'h10, 8'h00, TO + 2, 1'b1, "tmo10");
    wait_mode = 0;

    $display("[TB] reset during ACCESS");
    wait_mode = 2;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h07;
    @(posedge PCLK);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    checkOutput("midrst pre PENABLE", 32'(bus.PENABLE), 32'd1);
    #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("midrst PSEL1", 32'(bus.PSEL1), 32'd0);
    checkOutput("midrst PENABLE", 32'(bus.PENABLE), 32'd0);
    checkOutput("midrst req_ready", 32'(bus.req_ready), 32'd1);
    wait_mode = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      checkOutput("midrst no rsp", 32'(bus.rsp_valid), 32'd0);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    checkOutput("midrst after release no rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge PCLK);
    #1;
    applyStimulus(1'b1, 8'h07, 8'h99, 3, 1'b0, "wr07");
    applyStimulus(1'b0, 8'h07, 8'h00, 4, 1'b0, "rd07");

    $display("[TB] randomized traffic");
    wait_mode = 1;
    for (int t = 0; t < 40; t++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom),
                    -1, 1'b0, "rnd");
    end
    wait_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
